// File: rtl/alu_entry_sequencer_if.sv
// Command, ALU-bus and response signals between a host, the entry sequencer and the ALU datapath.
// master = host/datapath side, slave = sequencer side.
interface alu_entry_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_opcode;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic              enter;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] result_in;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, result_in, rsp_ready,
    input  cmd_ready, enter, data_out, rsp_valid, rsp_result
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, result_in, rsp_ready,
    output cmd_ready, enter, data_out, rsp_valid, rsp_result
  );
endinterface

// File: rtl/alu_entry_sequencer.sv
// Replays one ALU instruction as settle-then-enter phases (opcode, A, [B], OUT), (3 or 4)*(SETTLE+1) cycles,
// then holds the result until rsp_ready; cmd_ready is low while busy. ALU_SEQ_PHASE_EN adds the `phase` output.
module alu_entry_sequencer #(
  parameter int DATA_W = 8,
  parameter int SETTLE = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  alu_entry_sequencer_if.slave bus
`ifdef ALU_SEQ_PHASE_EN
  ,output logic [1:0]          phase
`endif
);
  typedef enum logic [2:0] {IDLE, PH_OP, PH_A, PH_B, PH_OUT, RESP} state_t;

  localparam logic [3:0] SETTLE_N = 4'(SETTLE);
  localparam logic [3:0] OP_NEG   = 4'b0010;
  localparam logic [3:0] OP_NOT   = 4'b0111;

  state_t            state;
  logic [3:0]        cnt;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] result_q;
  logic              enter_q;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic              single_op;

  assign single_op = (op_q == OP_NEG) || (op_q == OP_NOT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      data_q      <= '0;
      result_q    <= '0;
      enter_q     <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q        <= bus.cmd_opcode;
            a_q         <= bus.cmd_a;
            b_q         <= bus.cmd_b;
            data_q      <= DATA_W'(bus.cmd_opcode);
            cnt         <= '0;
            cmd_ready_q <= 1'b0;
            state       <= PH_OP;
          end
        end
        PH_OP, PH_A, PH_B, PH_OUT: begin
          if (cnt == SETTLE_N) begin
            // Enter cycle: the controller advances on this edge, so the next phase's value goes out now.
            cnt     <= '0;
            enter_q <= 1'b0;
            case (state)
              PH_OP: begin
                state  <= PH_A;
                data_q <= a_q;
              end
              PH_A: begin
                state  <= single_op ? PH_OUT : PH_B;
                data_q <= single_op ? '0 : b_q;
              end
              PH_B: begin
                state  <= PH_OUT;
                data_q <= '0;
              end
              default: begin
                state       <= RESP;
                data_q      <= '0;
                result_q    <= bus.result_in;
                rsp_valid_q <= 1'b1;
              end
            endcase
          end else begin
            cnt     <= cnt + 4'd1;
            enter_q <= (cnt + 4'd1 == SETTLE_N);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_PHASE_EN
  // Mirrors the controller's state; it only moves on the edge that ends an enter cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase <= 2'd0;
    end else if (enter_q) begin
      case (state)
        PH_OP:   phase <= 2'd1;
        PH_A:    phase <= single_op ? 2'd3 : 2'd2;
        PH_B:    phase <= 2'd3;
        default: phase <= 2'd0;
      endcase
    end
  end
`endif

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.enter      = enter_q;
  assign bus.data_out   = data_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = result_q;
endmodule

// File: tb/tb_alu_entry_sequencer.sv
// Self-checking bench: per-cycle trace model of the command/phase protocol plus literal timing pins.
module tb_alu_entry_sequencer;
  localparam int DW = 8;
  localparam int ST = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  alu_entry_sequencer_if #(.DATA_W(DW)) bus ();
`ifdef ALU_SEQ_PHASE_EN
  logic [1:0] phase;
`endif

  alu_entry_sequencer #(.DATA_W(DW), .SETTLE(ST)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
`ifdef ALU_SEQ_PHASE_EN
    ,.phase(phase)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a command expands into a list of per-cycle (enter, data, phase) steps, then a pending response.
  typedef struct packed {
    logic          en;
    logic [DW-1:0] d;
    logic [1:0]    ph;
  } step_t;

  step_t         trace[$];
  bit            resp_pend = 1'b0;
  logic [DW-1:0] rsp_exp   = '0;
  logic [DW-1:0] mv [4];
  int            cyc   = 0;
  int            acc_e = 0;
  int            ret_e = 0;

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      trace.delete();
      resp_pend = 1'b0;
      rsp_exp   = '0;
    end else begin
      cyc++;
      if (trace.size() > 0) begin
        void'(trace.pop_front());
        if (trace.size() == 0) begin
          resp_pend = 1'b1;
          rsp_exp   = bus.result_in;
        end
      end else if (resp_pend) begin
        if (bus.rsp_ready) begin
          resp_pend = 1'b0;
          ret_e     = cyc;
        end
      end else if (bus.cmd_valid) begin
        mv[0] = DW'(bus.cmd_opcode);
        mv[1] = bus.cmd_a;
        mv[2] = bus.cmd_b;
        mv[3] = '0;
        for (int p = 0; p < 4; p++) begin
          if (p == 2 && (bus.cmd_opcode == 4'd2 || bus.cmd_opcode == 4'd7)) continue;
          for (int k = 0; k <= ST; k++)
            trace.push_back(step_t'{en: (k == ST), d: mv[p], ph: 2'(p)});
        end
        acc_e = cyc;
      end
    end
  end

  // Compare process plus per-command observation log used by the literal pins.
  logic          e_rdy, e_en, e_rv;
  logic [DW-1:0] e_d;
  logic [1:0]    e_ph;
  logic          prev_en  = 1'b0;
  logic          prev_rv  = 1'b0;
  logic [1:0]    prev_ph  = 2'd0;
  int            seen_acc = 0;
  int            npulse   = 0;
  logic [31:0]   pk_cyc   = '0;
  logic [31:0]   pk_dat   = '0;
  bit            saw_aa   = 1'b0;
  int            rise     = -1;
  logic [DW-1:0] rise_res = '0;
  logic [31:0]   phv      = '0;
  int            phn      = 0;

  initial forever begin
    @(negedge clock);
    if (!reset) begin
      if (trace.size() > 0) begin
        e_rdy = 1'b0; e_en = trace[0].en; e_d = trace[0].d; e_rv = 1'b0; e_ph = trace[0].ph;
      end else begin
        e_rdy = !resp_pend; e_en = 1'b0; e_d = '0; e_rv = resp_pend; e_ph = 2'd0;
      end
      chk("cmd_ready",  bus.cmd_ready,  e_rdy);
      chk("enter",      bus.enter,      e_en);
      chk("data_out",   bus.data_out,   e_d);
      chk("rsp_valid",  bus.rsp_valid,  e_rv);
      chk("rsp_result", bus.rsp_result, rsp_exp);
      chk("enter_back_to_back", bus.enter & prev_en, 0);

      if (acc_e != seen_acc) begin
        seen_acc = acc_e;
        npulse = 0; pk_cyc = '0; pk_dat = '0; saw_aa = 1'b0; rise = -1;
`ifdef ALU_SEQ_PHASE_EN
        phv = 32'(phase); phn = 1;
`endif
      end
`ifdef ALU_SEQ_PHASE_EN
      else if (phase != prev_ph) begin
        phv = (phv << 2) | 32'(phase);
        phn++;
      end
      chk("phase", phase, e_ph);
      prev_ph = phase;
`endif
      if (bus.enter) begin
        npulse++;
        pk_cyc = (pk_cyc << 8) | 32'(8'(cyc - acc_e));
        pk_dat = (pk_dat << 8) | 32'(bus.data_out);
      end
      if (bus.data_out == 8'hAA) saw_aa = 1'b1;
      if (bus.rsp_valid && !prev_rv) begin
        rise     = cyc - acc_e;
        rise_res = bus.rsp_result;
      end
      prev_en = bus.enter;
      prev_rv = bus.rsp_valid;
    end
  end

  task automatic start_cmd(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] res, input bit keep);
    int n = 0;
    @(negedge clock);
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = op;
    bus.cmd_a      = a;
    bus.cmd_b      = b;
    bus.result_in  = res;
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("accept_within_budget", n < 100, 1);
    @(negedge clock);
    if (!keep) bus.cmd_valid = 1'b0;
  endtask

  task automatic finish_cmd(input int stall, input bit rnd);
    int n = 0;
    bus.rsp_ready = 1'b0;
    while (!bus.rsp_valid && n < 200) begin
      @(negedge clock);
      if (rnd) bus.result_in = 8'($urandom);
      n++;
    end
    chk("rsp_within_budget", n < 200, 1);
    repeat (stall) @(negedge clock);
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_opcode = '0; bus.cmd_a = '0; bus.cmd_b = '0;
    bus.result_in = '0;   bus.rsp_ready = 1'b0;
    #12;
    chk("reset_enter",      bus.enter,      0);
    chk("reset_data_out",   bus.data_out,   0);
    chk("reset_rsp_valid",  bus.rsp_valid,  0);
    chk("reset_rsp_result", bus.rsp_result, 0);
    @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    chk("ready_after_reset", bus.cmd_ready, 1);
    repeat (4) @(negedge clock);

    // Two-operand ADD
    start_cmd(4'h0, 8'h05, 8'h03, 8'h08, 1'b0);
    finish_cmd(1, 1'b0);
    chk("add_pulse_count",  npulse,   4);
    chk("add_pulse_cycles", pk_cyc,   32'h0205080B);
    chk("add_enter_data",   pk_dat,   32'h00050300);
    chk("add_rsp_cycle",    rise,     12);
    chk("add_rsp_result",   rise_res, 8'h08);

    // Single-operand NEG: B must never reach the bus
    start_cmd(4'h2, 8'h05, 8'hAA, 8'hFB, 1'b0);
    finish_cmd(0, 1'b0);
    chk("neg_pulse_count",  npulse,   3);
    chk("neg_pulse_cycles", pk_cyc,   32'h00020508);
    chk("neg_enter_data",   pk_dat,   32'h00020500);
    chk("neg_b_hidden",     saw_aa,   0);
    chk("neg_rsp_cycle",    rise,     9);
    chk("neg_rsp_result",   rise_res, 8'hFB);

    // Response backpressure with cmd_valid held high throughout
    start_cmd(4'h1, 8'h10, 8'h20, 8'h33, 1'b1);
    finish_cmd(5, 1'b0);
    chk("stall_rsp_result", rise_res, 8'h33);
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    chk("stall_reaccept_gap", acc_e - ret_e, 1);
    finish_cmd(0, 1'b0);

    // Reset in the enter cycle of PH_A
    start_cmd(4'h0, 8'h05, 8'h03, 8'h08, 1'b0);
    repeat (5) @(negedge clock);
    chk("pre_reset_enter", bus.enter,    1);
    chk("pre_reset_data",  bus.data_out, 8'h05);
    #2 reset = 1'b1;
    #1;
    chk("mid_reset_enter",      bus.enter,      0);
    chk("mid_reset_data_out",   bus.data_out,   0);
    chk("mid_reset_rsp_valid",  bus.rsp_valid,  0);
    chk("mid_reset_rsp_result", bus.rsp_result, 0);
    @(negedge clock);
    #2 reset = 1'b0;
    repeat (20) @(negedge clock);
    start_cmd(4'h0, 8'h05, 8'h03, 8'h08, 1'b0);
    finish_cmd(0, 1'b0);
    chk("post_reset_rsp_cycle",  rise,     12);
    chk("post_reset_rsp_result", rise_res, 8'h08);

`ifdef ALU_SEQ_PHASE_EN
    start_cmd(4'h0, 8'h11, 8'h22, 8'h33, 1'b0);
    finish_cmd(0, 1'b0);
    chk("add_phase_count", phn, 5);
    chk("add_phase_seq",   phv, 32'h0000006C);
    start_cmd(4'h7, 8'h0F, 8'h55, 8'hF0, 1'b0);
    finish_cmd(0, 1'b0);
    chk("not_phase_count", phn, 4);
    chk("not_phase_seq",   phv, 32'h0000001C);
`endif

    // Randomized commands, stalls and gaps; result_in changes every cycle
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
      start_cmd(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      finish_cmd(int'($urandom_range(0, 3)), 1'b1);
    end

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end
endmodule
